// File: rtl/debug_pkg.sv
// debug_pkg: frame geometry, FSM states and frame byte selection for the debug UART
package debug_pkg;
  localparam int SEQ_LEN = 20;
  localparam int SEQ_NUM = 6;
  localparam int SEQ_W = SEQ_LEN * SEQ_NUM;
  localparam int BYTES_PER_SEQ = (SEQ_LEN + 7) / 8;
  localparam int FRAME_BYTES = 1 + SEQ_NUM * BYTES_PER_SEQ + 1;
  localparam int IDX_W = $clog2(FRAME_BYTES + 1);
  localparam int PAD = 8 * BYTES_PER_SEQ - SEQ_LEN;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  // byte k of the frame excluding the checksum: 0 is SYNC, then sign-extended values MSB byte first
  function automatic logic [7:0] frame_byte(input logic [SEQ_W-1:0] seq, input logic [IDX_W-1:0] k);
    logic [SEQ_LEN-1:0] v;
    logic [8*BYTES_PER_SEQ-1:0] ext;
    int p;
    p = int'(k) - 1;
    if (p < 0) return SYNC_BYTE;
    if (p >= SEQ_NUM * BYTES_PER_SEQ) return 8'h00;
    v = seq[(p / BYTES_PER_SEQ) * SEQ_LEN +: SEQ_LEN];
    ext = {{PAD{v[SEQ_LEN-1]}}, v};
    return ext[(BYTES_PER_SEQ - 1 - p % BYTES_PER_SEQ) * 8 +: 8];
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser that can reload in the last stop-bit cycle for gapless bytes
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_busy,
  output logic       byte_done
);
  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0] bit_q, bit_d;
  logic [9:0] shift_q, shift_d;
  logic busy_q, busy_d, bit_end;
  assign bit_end = baud_q == BAUD_MAX;
  assign byte_done = busy_q && bit_end && bit_q == 4'd9;
  assign tx = shift_q[0];
  assign byte_busy = busy_q;
  // advance baud/bit counters and shift out; a start in the final stop cycle chains the next byte
  always_comb begin
    baud_d = busy_q && !bit_end ? baud_q + 1'b1 : '0;
    bit_d = busy_q && bit_end ? bit_q + 1'b1 : bit_q;
    shift_d = busy_q && bit_end ? {1'b1, shift_q[9:1]} : shift_q;
    busy_d = busy_q && !byte_done;
    if (start && (!busy_q || byte_done)) begin
      shift_d = {1'b1, data, 1'b0};
      busy_d = 1'b1;
      baud_d = '0;
      bit_d = '0;
    end
  end
  // state registers; the shifter resets to all ones so the line idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '1;
      busy_q <= 1'b0;
    end else begin
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: rtl/debug_uart_tx.sv
// debug_uart_tx: snapshots the debug bus on trigger and sends a SYNC/payload/XOR frame over UART
module debug_uart_tx
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             trigger,
  input  logic [SEQ_W-1:0] bcd_seq,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic             dropped
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_BYTES - 1);
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
  logic [SEQ_W-1:0] snap_q, snap_d;
  logic [7:0] chk_q, chk_d, byte_data;
  logic accept, start, byte_done, byte_busy;
  assign busy = byte_busy;
  assign frame_done = state_q == DONE;
  assign dropped = trigger && busy;
  assign accept = trigger && !busy;
  assign nxt_idx = accept ? '0 : idx_q + 1'b1;
  assign byte_data = nxt_idx == LAST ? chk_q : frame_byte(snap_q, nxt_idx);
  // frame sequencing: start SYNC on accept, chain each following byte on byte_done, fold payload into checksum
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    snap_d = snap_q;
    chk_d = chk_q;
    start = 1'b0;
    if (accept) begin
      state_d = SEND;
      idx_d = '0;
      snap_d = bcd_seq;
      chk_d = '0;
      start = 1'b1;
    end else if (state_q == SEND && byte_done) begin
      state_d = idx_q == LAST ? DONE : SEND;
      idx_d = idx_q == LAST ? idx_q : nxt_idx;
      start = idx_q != LAST;
      chk_d = nxt_idx < LAST ? chk_q ^ byte_data : chk_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // frame state, byte index, snapshot and checksum registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      snap_q <= '0;
      chk_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      snap_q <= snap_d;
      chk_q <= chk_d;
    end
  end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk(sys_clk),
    .rst(sys_rst),
    .start(start),
    .data(byte_data),
    .tx(tx),
    .byte_busy(byte_busy),
    .byte_done(byte_done)
  );
endmodule

// File: tb/tb_debug_uart_tx.sv
// tb_debug_uart_tx: table-driven frames checked by a UART-decoding scoreboard plus timing corner cases
module tb_debug_uart_tx;
  import debug_pkg::*;
  localparam int CPB = 4;
  localparam int FRAME_CYC = 20 * 10 * CPB;
  typedef struct {
    logic [SEQ_W-1:0] seq;
    logic [7:0] chk;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, trigger = 1'b0;
  logic [SEQ_W-1:0] bcd_seq = '0;
  logic tx, busy, frame_done, dropped;
  int checks = 0, failures = 0, cyc = 0, drop_cnt = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[5];

  debug_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .trigger(trigger),
    .bcd_seq(bcd_seq),
    .tx(tx),
    .busy(busy),
    .frame_done(frame_done),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dropped) drop_cnt <= drop_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SEQ_W-1:0] pack6(input logic [19:0] a, b, c, d, e, f);
    return {f, e, d, c, b, a};
  endfunction

  function automatic logic [7:0] model_byte(input logic [SEQ_W-1:0] s, input int k);
    logic signed [23:0] e;
    if (k == 0) return 8'hA5;
    e = $signed(s[((k - 1) / 3) * 20 +: 20]);
    return e[8 * (2 - (k - 1) % 3) +: 8];
  endfunction

  task automatic push_frame(input logic [SEQ_W-1:0] s, input logic [7:0] chk);
    for (int k = 0; k < 19; k++) exp_q.push_back(model_byte(s, k));
    exp_q.push_back(chk);
  endtask

  task automatic fire();
    @(posedge clk);
    #1 trigger = 1'b1;
    @(posedge clk);
    #1 trigger = 1'b0;
  endtask

  task automatic wait_done(output int t);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 2 * FRAME_CYC) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (frame_done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL frame_done_timeout: got no pulse expected pulse within %0d cycles", 2 * FRAME_CYC);
    end
    t = cyc;
  endtask

  initial begin : mon
    logic [7:0] d;
    logic ok;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clk);
          ok = ok && !rst;
          d[b] = tx;
        end
        repeat (CPB) @(negedge clk);
        ok = ok && !rst;
        if (ok) begin
          check("stop_bit", tx, 1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte: got %h expected none", d);
          end else check("rx_byte", d, exp_q.pop_front());
          repeat (CPB - 1) @(negedge clk);
        end
      end
    end
  end

  initial begin
    int t0, t1, d0;
    vecs[0] = '{pack6(20'h00005, 20'hFFFFE, 0, 0, 0, 0), 8'hFB};
    vecs[1] = '{pack6(0, 0, 0, 0, 0, 0), 8'h00};
    vecs[2] = '{pack6(20'h80000, 0, 0, 0, 0, 0), 8'hF8};
    vecs[3] = '{pack6(0, 0, 0, 0, 0, 20'h7FFFF), 8'h07};
    vecs[4] = '{pack6(0, 0, 20'h12345, 20'hABCDE, 0, 0), 8'hFF};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_outputs", {tx, busy, frame_done, dropped}, 4'b1000);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 check("idle_outputs", {tx, busy, frame_done, dropped}, 4'b1000);
    end
    for (int i = 0; i < 5; i++) begin
      bcd_seq = vecs[i].seq;
      push_frame(vecs[i].seq, vecs[i].chk);
      fire();
      check("start_tx", tx, 0);
      check("start_busy", busy, 1);
      t0 = cyc;
      wait_done(t1);
      check("frame_len", t1 - t0, FRAME_CYC);
      check("done_busy", busy, 0);
      repeat (5) @(posedge clk);
      #1;
    end
    bcd_seq = vecs[4].seq;
    push_frame(vecs[4].seq, vecs[4].chk);
    fire();
    repeat (10) @(posedge clk);
    #1 bcd_seq = '1;
    wait_done(t1);
    bcd_seq = vecs[2].seq;
    push_frame(vecs[2].seq, vecs[2].chk);
    fire();
    t0 = cyc;
    d0 = drop_cnt;
    repeat (99) @(posedge clk);
    #1 trigger = 1'b1;
    @(posedge clk);
    #1 trigger = 1'b0;
    check("drop_pulse", drop_cnt - d0, 1);
    wait_done(t1);
    check("drop_frame_len", t1 - t0, FRAME_CYC);
    repeat (100) @(posedge clk);
    #1 check("no_second_frame", {tx, busy}, 2'b10);
    check("drop_count_total", drop_cnt - d0, 1);
    bcd_seq = vecs[3].seq;
    push_frame(vecs[3].seq, vecs[3].chk);
    fire();
    wait_done(t1);
    push_frame(vecs[3].seq, vecs[3].chk);
    trigger = 1'b1;
    #1 check("b2b_no_drop", dropped, 0);
    @(posedge clk);
    #1 trigger = 1'b0;
    check("b2b_start", {tx, busy, frame_done}, 3'b010);
    t0 = cyc;
    wait_done(t1);
    check("b2b_frame_len", t1 - t0, FRAME_CYC);
    repeat (5) @(posedge clk);
    bcd_seq = vecs[0].seq;
    push_frame(vecs[0].seq, vecs[0].chk);
    fire();
    repeat (200) @(posedge clk);
    #3 check("byte5_start_bit", tx, 0);
    rst = 1'b1;
    #1 check("async_reset", {tx, busy, frame_done}, 3'b100);
    exp_q.delete();
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    repeat (50) @(posedge clk);
    #1 check("post_reset_idle", {tx, busy}, 2'b10);
    bcd_seq = vecs[4].seq;
    push_frame(vecs[4].seq, vecs[4].chk);
    fire();
    t0 = cyc;
    wait_done(t1);
    check("post_reset_frame_len", t1 - t0, FRAME_CYC);
    repeat (20) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
